// File: rtl/shift_add_mult_ctrl.sv
// Sequential 16x16 unsigned shift-add multiplier: one shared 16-bit adder, 16 iterations,
// start/done handshake around a three-state controller.

module fulladder_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
endmodule

module shift_add_mult_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [1:0]  dbg_state
);
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  // Handshake: start is only looked at while ready=1; the rising edge that sees
  // ready=1 and start=1 captures both operands. done is a one-cycle pulse and
  // product stays valid from that cycle until the next accepted start.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_add_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_next_acc;
  logic               w_last_iter;

  assign w_add_b = r_acc_lo[0] ? r_mcand : '0;

  fulladder_16b u_adder (
    .a    (r_acc_hi),
    .b    (w_add_b),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Carry becomes the new MSB so nothing is lost; the old accumulator LSB drops out.
  assign w_next_acc  = {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};
  assign w_last_iter = (r_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_CALC;
      S_CALC:  if (w_last_iter) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_mcand   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= multiplicand;
            r_acc_lo <= multiplier;
            r_acc_hi <= '0;
            r_count  <= '0;
          end
        end
        S_CALC: begin
          {r_acc_hi, r_acc_lo} <= w_next_acc;
          r_count              <= r_count + 1'b1;
          if (w_last_iter) r_product <= w_next_acc;
        end
        default: ;
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign busy      = (r_state == S_CALC) || (r_state == S_DONE);
  assign done      = (r_state == S_DONE);
  assign product   = r_product;
  assign dbg_state = r_state;

endmodule
